// File: rtl/common_pkg.sv
// Generic arithmetic helpers shared by the modular-arithmetic packages.
// mulmod: (a*b) mod m on 64-bit operands with a 128-bit intermediate.
package common_pkg;

  function automatic logic [63:0] mulmod(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] m
  );
    logic [127:0] t;
    t = a * b;
    return 64'(t % {64'd0, m});
  endfunction

endpackage

// File: rtl/redun_mont_pkg.sv
// Sizing, types and reference helpers for the redundant Montgomery squarer.
// Small config: P=0xFFF1, 3 digits of 8 bits stored in 10 bits, R=2^24.
package redun_mont_pkg;
  import common_pkg::*;

  localparam int WORD_BITS       = 8;
  localparam int REDUN_WORD_BITS = WORD_BITS + 2;
  localparam int NUM_WRDS        = 3;
  localparam int FE_BITS         = WORD_BITS * NUM_WRDS;
  localparam int T_LEN           = 64;

  typedef logic [FE_BITS-1:0] fe_t;
  typedef logic [NUM_WRDS-1:0][REDUN_WORD_BITS-1:0] redun0_t;

  localparam fe_t P = fe_t'('hFFF1);

  // Newton iteration doubles the number of correct low bits each pass;
  // an odd P is its own inverse mod 8, so six passes cover 24+ bits.
  function automatic fe_t calc_minv();
    fe_t inv;
    inv = P;
    for (int i = 0; i < 6; i++)
      inv = inv * (fe_t'(2) - P * inv);
    return fe_t'(0) - inv;
  endfunction

  localparam fe_t MINV = calc_minv();

  localparam logic [63:0] R_MOD_P =
    (64'd1 << FE_BITS) % 64'(P);

  function automatic redun0_t to_redun(input fe_t v);
    redun0_t r;
    r = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      r[i] = REDUN_WORD_BITS'(v[i*WORD_BITS +: WORD_BITS]);
    return r;
  endfunction

  function automatic fe_t from_redun(input redun0_t r);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      s = s + (64'(r[i]) << (WORD_BITS * i));
    return fe_t'(s % 64'(P));
  endfunction

  function automatic fe_t to_mont(input fe_t v);
    return fe_t'(mulmod(64'(v), R_MOD_P, 64'(P)));
  endfunction

  // a*b*R^-1 mod P by repeated halving mod P
  function automatic fe_t fe_mul_mont(input fe_t a, input fe_t b);
    logic [63:0] t;
    t = mulmod(64'(a), 64'(b), 64'(P));
    for (int i = 0; i < FE_BITS; i++)
      t = t[0] ? (t + 64'(P)) >> 1 : t >> 1;
    return fe_t'(t);
  endfunction

  function automatic fe_t from_mont(input fe_t v);
    return fe_mul_mont(v, fe_t'(1));
  endfunction

  function automatic fe_t mod_sq(input fe_t a, input int n);
    logic [63:0] t;
    t = 64'(a) % 64'(P);
    for (int i = 0; i < n; i++)
      t = mulmod(t, t, 64'(P));
    return fe_t'(t);
  endfunction

endpackage

// File: rtl/redun_mul.sv
// Full multiplier on digit vectors of weight 2^(WORD_BITS*i).
// i_a/i_b: NUM_WRDS digits of DW_A/DW_B bits; o_p: binary product, OW bits.
module redun_mul
  import redun_mont_pkg::*;
#(
  parameter int DW_A = REDUN_WORD_BITS,
  parameter int DW_B = REDUN_WORD_BITS,
  parameter int OW   = 2 * FE_BITS
) (
  input  logic [NUM_WRDS*DW_A-1:0] i_a,
  input  logic [NUM_WRDS*DW_B-1:0] i_b,
  output logic [OW-1:0]            o_p
);

  logic [OW-1:0] w_a;
  logic [OW-1:0] w_b;

  // Digits overlap by the carry headroom; summing them at their
  // weights absorbs the carries into a plain binary value.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      w_a = w_a + (OW'(i_a[i*DW_A +: DW_A]) << (WORD_BITS * i));
      w_b = w_b + (OW'(i_b[i*DW_B +: DW_B]) << (WORD_BITS * i));
    end
    o_p = w_a * w_b;
  end

endmodule

// File: rtl/redun_mont.sv
// Free-running Montgomery squarer: x <= x*x*R^-1 mod P, one result / 3 clk.
// i_sq/i_val seed the loop; o_mul/o_val emit every result (value < 2P).
module redun_mont
  import redun_mont_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  redun0_t i_sq,
  input  logic    i_val,
  output redun0_t o_mul,
  output logic    o_val
);

  localparam int SW = 2 * FE_BITS;

  redun0_t       r_x;
  redun0_t       r_mul;
  redun0_t       w_x;
  redun0_t       w_y;
  logic          r_v0;
  logic          r_v1;
  logic          r_v2;
  logic          r_val;
  logic [SW-1:0] r_s;
  logic [SW-1:0] r_s2;
  logic [SW-1:0] w_sq;
  logic [SW-1:0] w_qp;
  logic [SW-1:0] w_sum;
  fe_t           r_q;
  fe_t           w_q;
  logic          w_unused_lo;

  // A fresh seed takes priority; otherwise the last result loops back.
  assign w_x = r_v0 ? r_x : r_mul;

  redun_mul #(
    .DW_A (REDUN_WORD_BITS),
    .DW_B (REDUN_WORD_BITS),
    .OW   (SW)
  ) u_sq (
    .i_a (w_x),
    .i_b (w_x),
    .o_p (w_sq)
  );

  redun_mul #(
    .DW_A (WORD_BITS),
    .DW_B (WORD_BITS),
    .OW   (FE_BITS)
  ) u_q (
    .i_a (r_s[FE_BITS-1:0]),
    .i_b (MINV),
    .o_p (w_q)
  );

  redun_mul #(
    .DW_A (WORD_BITS),
    .DW_B (WORD_BITS),
    .OW   (SW)
  ) u_qp (
    .i_a (r_q),
    .i_b (P),
    .o_p (w_qp)
  );

  assign w_sum = r_s2 + w_qp;

  // q is chosen so the low half of S+q*P is zero; only the high half
  // carries information.
  assign w_unused_lo = ^w_sum[FE_BITS-1:0];

  // y < 2P fits in FE_BITS, so each digit gets one clean byte and the
  // carry headroom is left zero.
  always_comb begin
    w_y = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      w_y[i] = REDUN_WORD_BITS'(
        w_sum[FE_BITS + i*WORD_BITS +: WORD_BITS]);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_x   <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_val <= 1'b0;
      r_mul <= '0;
      r_s   <= '0;
      r_s2  <= '0;
      r_q   <= '0;
    end else begin
      r_s  <= w_sq;
      r_s2 <= r_s;
      r_q  <= w_q;
      if (i_val) begin
        // Reseed kills whatever is in flight, including a result
        // that would land on this very edge.
        r_x   <= i_sq;
        r_v0  <= 1'b1;
        r_v1  <= 1'b0;
        r_v2  <= 1'b0;
        r_val <= 1'b0;
      end else begin
        r_v0  <= 1'b0;
        r_v1  <= r_v0 | r_val;
        r_v2  <= r_v1;
        r_val <= r_v2;
        if (r_v2)
          r_mul <= w_y;
      end
    end
  end

  assign o_mul = r_mul;
  assign o_val = r_val;

endmodule

// File: tb/tb_redun_mont.sv
// Directed bench for redun_mont: seed table, chained squares, long run,
// reseed, reset and boundary cases against hand-computed values.
module tb_redun_mont;
  import redun_mont_pkg::*;

  typedef struct {
    redun0_t seed;
    fe_t     exp;
  } vec_t;

  logic    clk;
  logic    i_rst;
  redun0_t i_sq;
  logic    i_val;
  redun0_t o_mul;
  logic    o_val;

  int n_vec;
  int n_bad;

  redun_mont dut (
    .i_clk (clk),
    .i_rst (i_rst),
    .i_sq  (i_sq),
    .i_val (i_val),
    .o_mul (o_mul),
    .o_val (o_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] raw_val(input redun0_t r);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < NUM_WRDS; i++)
      s = s + (64'(r[i]) << (WORD_BITS * i));
    return s;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic seed(input redun0_t v);
    i_sq  = v;
    i_val = 1'b1;
    @(negedge clk);
    i_val = 1'b0;
    i_sq  = '0;
  endtask

  // Two quiet cycles, then a pulse carrying exp (mod P) with value < 2P.
  task automatic expect_pulse(
    input  string nm,
    input  fe_t   exp,
    output bit    ok
  );
    int bad0;
    bad0 = n_bad;
    repeat (2) begin
      @(negedge clk);
      chk({nm, " gap"}, 64'(o_val), 64'd0);
    end
    @(negedge clk);
    chk({nm, " val"}, 64'(o_val), 64'd1);
    chk({nm, " mod"}, 64'(from_redun(o_mul)), 64'(exp));
    chk({nm, " bound"}, 64'(raw_val(o_mul) < 64'(2 * P)), 64'd1);
    ok = (n_bad == bad0);
  endtask

  initial begin
    vec_t             tbl [5];
    fe_t              chain [4];
    redun0_t          bnd;
    fe_t              prev;
    logic [T_LEN-1:0] cnt;
    bit               ok;
    int               hits;

    n_vec = 0;
    n_bad = 0;
    i_rst = 1'b0;
    i_val = 1'b0;
    i_sq  = '0;

    // 2P-1 = 131041 = 993 + 508*256 with carry-heavy low digits
    bnd    = '0;
    bnd[0] = REDUN_WORD_BITS'(993);
    bnd[1] = REDUN_WORD_BITS'(508);

    tbl[0].seed = to_redun(fe_t'(7680));   // mont(2)
    tbl[0].exp  = fe_t'(15360);
    tbl[1].seed = to_redun(fe_t'(11520));  // mont(3)
    tbl[1].exp  = fe_t'(34560);
    tbl[2].seed = bnd;                     // (P-1)^2=1 -> R^-1
    tbl[2].exp  = fe_t'(4078);
    tbl[3].seed = to_redun(fe_t'(3840));   // mont(1)
    tbl[3].exp  = fe_t'(3840);
    tbl[4].seed = to_redun(fe_t'(0));
    tbl[4].exp  = fe_t'(0);

    chain[0] = fe_t'(15360);
    chain[1] = fe_t'(61440);
    chain[2] = fe_t'(225);
    chain[3] = fe_t'(57600);

    #1;
    chk("reset o_val", 64'(o_val), 64'd0);
    chk("reset o_mul", raw_val(o_mul), 64'd0);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_val) hits++;
    end
    chk("idle before seed", 64'(hits), 64'd0);

    for (int i = 0; i < 5; i++) begin
      seed(tbl[i].seed);
      expect_pulse($sformatf("vec%0d", i), tbl[i].exp, ok);
    end

    seed(to_redun(to_mont(fe_t'(2))));
    cnt = '0;
    for (int k = 0; k < 4; k++) begin
      expect_pulse($sformatf("chain%0d", k), chain[k], ok);
      cnt++;
    end

    prev = from_redun(o_mul);
    while (cnt < 10000) begin
      expect_pulse("long", fe_mul_mont(prev, prev), ok);
      cnt++;
      prev = from_redun(o_mul);
      if (!ok) break;
    end
    chk("long count", 64'(cnt), 64'd10000);
    chk("long final", 64'(from_mont(prev)),
        64'(mod_sq(fe_t'(2), 10000)));

    @(negedge clk);
    seed(to_redun(to_mont(fe_t'(3))));
    expect_pulse("reseed mid", fe_t'(34560), ok);

    repeat (2) @(negedge clk);
    seed(to_redun(to_mont(fe_t'(5))));
    chk("stale val", 64'(o_val), 64'd0);
    chk("stale hold", 64'(from_redun(o_mul)), 64'd34560);
    expect_pulse("reseed edge", fe_t'(30479), ok);

    #1 i_rst = 1'b0;
    #1;
    chk("async o_val", 64'(o_val), 64'd0);
    chk("async o_mul", raw_val(o_mul), 64'd0);
    @(negedge clk);
    i_rst = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_val) hits++;
    end
    chk("idle after reset", 64'(hits), 64'd0);

    seed(to_redun(to_mont(fe_t'(2))));
    expect_pulse("recover", fe_t'(15360), ok);
    @(negedge clk);
    #1 i_rst = 1'b0;
    #1;
    chk("mid-iter o_mul", raw_val(o_mul), 64'd0);
    @(negedge clk);
    i_rst = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_val) hits++;
    end
    chk("idle after mid-iter", 64'(hits), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
